// File: rtl/router_in_arb.sv
// Three-source round-robin input arbiter feeding a byte-serial router port.
// Holds a grant for one whole packet, enforces an idle gap between packets and aborts stalled grants.
module router_in_arb #(
    parameter int DW      = 8,
    parameter int GAP_CYC = 2,
    parameter int TMO     = 31
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [2:0]    req,
    input  logic [DW-1:0] src_data_0,
    input  logic [DW-1:0] src_data_1,
    input  logic [DW-1:0] src_data_2,
    input  logic [2:0]    src_valid,
    input  logic          busy,
    output logic [2:0]    gnt,
    output logic [2:0]    src_ready,
    output logic [DW-1:0] data_out,
    output logic          pkt_valid_out,
    output logic          abort
);

    localparam int CMAX = (TMO > GAP_CYC) ? TMO : GAP_CYC;
    localparam int CW   = ($clog2(CMAX + 1) < 5) ? 5 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_xfer;
    logic          accept;
    logic          cur_valid;
    logic          stall_hit;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic [DW-1:0] data_sel;
    logic [DW-1:0] src_data_a [3];
    logic [DW-1:0] masked [3];

    assign src_data_a[0] = src_data_0;
    assign src_data_a[1] = src_data_1;
    assign src_data_a[2] = src_data_2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mask
            assign masked[gi] = gnt_q[gi] ? src_data_a[gi] : '0;
        end
    endgenerate

    assign data_sel  = masked[0] | masked[1] | masked[2];
    assign in_xfer   = (state_q == S_XFER);
    assign accept    = in_xfer & ~busy;
    assign cur_valid = |(src_valid & gnt_q);
    // Timeout fires only on a busy cycle, so it can never coincide with an accepted byte.
    assign stall_hit = in_xfer & busy & (cnt_q >= CW'(TMO - 1));

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(ptr_q) + k) % 3);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    gnt_d   = 3'b001 << win_idx;
                    ptr_d   = win_idx;
                    state_d = S_XFER;
                end else begin
                    gnt_d = '0;
                end
            end
            S_XFER: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!cur_valid) begin
                        gnt_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (stall_hit) begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q < CW'(TMO)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                // Count consecutive quiet cycles; any busy cycle restarts the gap.
                if (busy) begin
                    cnt_d = '0;
                end else if (cnt_q >= CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt           = gnt_q;
        src_ready     = '0;
        data_out      = '0;
        pkt_valid_out = 1'b0;
        abort         = stall_hit;
        if (in_xfer) begin
            src_ready     = busy ? 3'b000 : gnt_q;
            data_out      = data_sel;
            pkt_valid_out = cur_valid;
        end
    end

endmodule

// File: tb/tb_router_in_arb.sv
// Randomized bench for router_in_arb: drivers queue packets per source, a negedge monitor
// checks every cycle against a packet-level arbitration model and a per-source byte scoreboard.
module tb_router_in_arb;

    localparam int DW      = 8;
    localparam int GAP_CYC = 2;
    localparam int TMO     = 31;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic [2:0]    req  = '0;
    logic [2:0]    src_valid = '0;
    logic          busy = 1'b0;
    logic [DW-1:0] sd [3];
    logic [DW-1:0] src_data_0, src_data_1, src_data_2;
    logic [2:0]    gnt, src_ready;
    logic [DW-1:0] data_out;
    logic          pkt_valid_out, abort;

    assign src_data_0 = sd[0];
    assign src_data_1 = sd[1];
    assign src_data_2 = sd[2];

    router_in_arb #(.DW(DW), .GAP_CYC(GAP_CYC), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .req(req),
        .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2),
        .src_valid(src_valid), .busy(busy), .gnt(gnt), .src_ready(src_ready),
        .data_out(data_out), .pkt_valid_out(pkt_valid_out), .abort(abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Each beat is {pkt_valid, byte}; drivers consume drv_q, the monitor consumes sb_q.
    logic [DW:0] drv_q [3][$];
    logic [DW:0] sb_q  [3][$];
    int          dut_glog[$];
    int          abort_cnt = 0;
    int          rdy_cnt [3];
    logic [2:0]  prev_gnt = '0;

    int  mode        = 1;
    int  start_pct   = 0;
    bit  allow_start = 1'b0;
    int  cyc         = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the port this cycle, last winner, stall run and quiet run.
    int m_owner = -1;
    int m_last  = 2;
    int m_stall = 0;
    int m_quiet = GAP_CYC;

    always @(negedge clk) begin
        if (!rstn) begin
            m_owner = -1;
            m_last  = 2;
            m_stall = 0;
            m_quiet = GAP_CYC;
            for (int i = 0; i < 3; i++) sb_q[i].delete();
        end else begin : mon
            logic [2:0]  e_gnt;
            logic [2:0]  e_rdy;
            logic        e_ab;
            logic [DW:0] head;
            e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            e_rdy = busy ? 3'b000 : e_gnt;
            e_ab  = (m_owner >= 0) && busy && (m_stall + 1 == TMO);
            chk("gnt", gnt, e_gnt);
            chk("src_ready", src_ready, e_rdy);
            chk("abort", abort, e_ab);
            if (m_owner >= 0) begin
                if (sb_q[m_owner].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow t=%0t src=%0d gnt=%0b", $time, m_owner, gnt);
                    m_owner = -1;
                    m_quiet = 0;
                end else begin
                    head = sb_q[m_owner][0];
                    chk("data_out", data_out, head[DW-1:0]);
                    chk("pkt_valid_out", pkt_valid_out, head[DW]);
                    if (!busy) begin
                        void'(sb_q[m_owner].pop_front());
                        m_stall = 0;
                        if (!head[DW]) begin
                            m_owner = -1;
                            m_quiet = 0;
                        end
                    end else begin
                        m_stall++;
                        if (m_stall == TMO) begin
                            sb_q[m_owner].delete();
                            m_owner = -1;
                            m_quiet = 0;
                            abort_cnt++;
                        end
                    end
                end
            end else begin
                chk("data_out_idle", data_out, 0);
                chk("pkt_valid_idle", pkt_valid_out, 0);
                if (m_quiet < GAP_CYC) begin
                    m_quiet = busy ? 0 : m_quiet + 1;
                end else if (req != 3'b000) begin
                    for (int k = 1; k <= 3; k++)
                        if (m_owner < 0 && req[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
                    m_last  = m_owner;
                    m_stall = 0;
                end
            end
        end
    end

    // Observed grant order and per-source acceptance counts, taken from the DUT pins.
    always @(negedge clk) begin
        if (rstn) begin
            if (gnt != 3'b000 && prev_gnt == 3'b000)
                dut_glog.push_back(gnt[0] ? 0 : (gnt[1] ? 1 : 2));
            for (int i = 0; i < 3; i++) if (src_ready[i]) rdy_cnt[i]++;
            prev_gnt = gnt;
        end else begin
            prev_gnt = 3'b000;
        end
    end

    task automatic push_beat(int i, logic v, logic [DW-1:0] d);
        drv_q[i].push_back({v, d});
        sb_q[i].push_back({v, d});
    endtask

    task automatic new_packet(int i);
        int            n;
        logic [DW-1:0] par;
        logic [DW-1:0] b;
        n   = $urandom_range(1, 4);
        par = '0;
        for (int k = 0; k < n; k++) begin
            b = DW'($urandom);
            par ^= b;
            push_beat(i, 1'b1, b);
        end
        push_beat(i, 1'b0, par);
        req[i] = 1'b1;
    endtask

    task automatic present();
        for (int i = 0; i < 3; i++) begin
            if (drv_q[i].size() > 0) begin
                sd[i]        = drv_q[i][0][DW-1:0];
                src_valid[i] = drv_q[i][0][DW];
            end else begin
                sd[i]        = DW'($urandom);
                src_valid[i] = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        logic [2:0]  acc;
        logic [2:0]  ab_g;
        logic [DW:0] b;
        @(negedge clk);
        acc  = src_ready;
        ab_g = abort ? gnt : 3'b000;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (acc[i] && drv_q[i].size() > 0) begin
                b = drv_q[i].pop_front();
                if (!b[DW]) req[i] = 1'b0;
            end
            if (ab_g[i]) begin
                drv_q[i].delete();
                req[i] = 1'b0;
            end
            if (allow_start && drv_q[i].size() == 0 && $urandom_range(0, 99) < start_pct)
                new_packet(i);
        end
        present();
        case (mode)
            0:       busy = ($urandom_range(0, 3) == 0);
            1:       busy = 1'b0;
            default: busy = ((cyc % 90) < 40);
        endcase
    endtask

    initial begin
        int w;
        int g0;
        for (int i = 0; i < 3; i++) begin
            sd[i]      = '0;
            rdy_cnt[i] = 0;
        end
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_pkt_valid", pkt_valid_out, 0);
        chk("rst_abort", abort, 0);

        // Single fixed packet on source 0 with no stalls.
        push_beat(0, 1'b1, 8'h01);
        push_beat(0, 1'b1, 8'hAA);
        push_beat(0, 1'b1, 8'hBB);
        push_beat(0, 1'b0, 8'hCA);
        req = 3'b001;
        present();
        rstn = 1'b1;
        step();
        chk("single_first_gnt", gnt, 3'b001);
        repeat (11) step();
        chk("single_ready_pulses", rdy_cnt[0], 4);
        chk("single_gnt_after", gnt, 0);

        // Random traffic with short random stalls.
        mode = 0; start_pct = 30; allow_start = 1'b1;
        repeat (1500) step();

        // All three sources requesting back-to-back: strict rotation.
        mode = 1; start_pct = 100;
        g0 = dut_glog.size();
        repeat (300) step();
        for (int k = g0 + 2; k + 1 < dut_glog.size(); k++)
            chk("rr_order", dut_glog[k + 1], (dut_glog[k] + 1) % 3);

        // Long stall windows that force timeouts.
        mode = 2; start_pct = 30;
        w = abort_cnt;
        repeat (900) step();
        chk("abort_seen", (abort_cnt > w) ? 1 : 0, 1);

        // Asynchronous reset in the middle of a source-1 packet.
        mode = 1; start_pct = 100;
        w = 0;
        while (gnt != 3'b010 && w < 200) begin
            step();
            w++;
        end
        if (w >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_src1_grant t=%0t gnt=%0b required=010", $time, gnt);
        end
        #2 rstn = 1'b0;
        #1;
        chk("async_gnt", gnt, 0);
        chk("async_src_ready", src_ready, 0);
        chk("async_data_out", data_out, 0);
        chk("async_pkt_valid", pkt_valid_out, 0);
        chk("async_abort", abort, 0);
        @(posedge clk);
        #1;
        allow_start = 1'b0;
        for (int i = 0; i < 3; i++) drv_q[i].delete();
        req = 3'b000;
        new_packet(0);
        new_packet(1);
        present();
        rstn = 1'b1;
        step();
        chk("post_reset_gnt", gnt, 3'b001);

        // Let everything outstanding finish.
        w = 0;
        while ((drv_q[0].size() + drv_q[1].size() + drv_q[2].size()) > 0 && w < 400) begin
            step();
            w++;
        end
        if (w >= 400) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout t=%0t left=%0d", $time,
                     drv_q[0].size() + drv_q[1].size() + drv_q[2].size());
        end
        repeat (4) step();
        chk("sb_leftover", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
